// File: rtl/bird_bus_pkg.sv
// Shared bus definitions for the bird CPU memory subsystem: FSM state
// encoding and default RAM geometry used by bird and the I/O blocks.
package bird_bus_pkg;

  localparam int unsigned BIRD_ADDR_W = 12;
  localparam int unsigned BIRD_DATA_W = 16;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_ADDR_ENC = 2'd1;
  localparam logic [1:0] ST_DATA_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_ADDR = ST_ADDR_ENC,
    ST_DATA = ST_DATA_ENC
  } bird_state_e;

endpackage

// File: rtl/bird_rr_pick.sv
// Two-way round-robin picker: among masked requests, a tie goes to the
// master that was not served last.
module bird_rr_pick (
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic [1:0] mask_i,
  output logic       gnt_c_o,
  output logic       valid_c_o
);

  logic [1:0] elig;

  always_comb begin
    elig      = req_i & mask_i;
    valid_c_o = |elig;
    gnt_c_o   = 1'b0;
    case (elig)
      2'b10:   gnt_c_o = 1'b1;
      2'b11:   gnt_c_o = ~last_i;
      default: gnt_c_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/bird_mem_arbiter.sv
// Two-master arbiter for the bird single-port RAM. One access per grant,
// sequenced IDLE -> ADDR -> DATA, with round-robin and bounded locking.
module bird_mem_arbiter
  import bird_bus_pkg::*;
#(
  parameter int unsigned ADDR_W   = BIRD_ADDR_W,
  parameter int unsigned DATA_W   = BIRD_DATA_W,
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_lock,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner
);

  localparam int unsigned CNT_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;

  bird_state_e       state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              locked_q, locked_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic              we_cap_q, we_cap_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              ack_q, ack_d;

  logic       owner_req;
  logic       owner_lock;
  logic [1:0] mask;
  logic       pick_gnt;
  logic       pick_valid;

  // While locked only the owner may win; a locked owner that stops
  // requesting releases the lock and normal arbitration applies.
  always_comb begin
    owner_req  = owner_q ? m1_req  : m0_req;
    owner_lock = owner_q ? m1_lock : m0_lock;
    mask       = 2'b11;
    if (locked_q && owner_req) begin
      mask = owner_q ? 2'b10 : 2'b01;
    end
  end

  bird_rr_pick u_pick (
    .req_i     ({m1_req, m0_req}),
    .last_i    (last_q),
    .mask_i    (mask),
    .gnt_c_o   (pick_gnt),
    .valid_c_o (pick_valid)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    locked_d    = locked_q;
    lock_cnt_d  = lock_cnt_q;
    we_cap_d    = we_cap_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    ack_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (locked_q && !owner_req) begin
          locked_d   = 1'b0;
          lock_cnt_d = '0;
        end
        if (pick_valid) begin
          owner_d     = pick_gnt;
          last_d      = pick_gnt;
          we_cap_d    = pick_gnt ? m1_we    : m0_we;
          mem_addr_d  = pick_gnt ? m1_addr  : m0_addr;
          mem_wdata_d = pick_gnt ? m1_wdata : m0_wdata;
          mem_we_d    = pick_gnt ? m1_we    : m0_we;
          state_d     = ST_ADDR;
        end
      end
      ST_ADDR: begin
        ack_d   = 1'b1;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (owner_lock && (lock_cnt_q < CNT_W'(MAX_LOCK - 1))) begin
          locked_d   = 1'b1;
          lock_cnt_d = lock_cnt_q + CNT_W'(1);
        end else begin
          locked_d   = 1'b0;
          lock_cnt_d = '0;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      locked_q    <= 1'b0;
      lock_cnt_q  <= '0;
      we_cap_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      locked_q    <= locked_d;
      lock_cnt_q  <= lock_cnt_d;
      we_cap_q    <= we_cap_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      ack_q       <= ack_d;
    end
  end

  // Read data passes straight from the RAM during the owner's ack cycle.
  assign m0_ack    = ack_q & ~owner_q;
  assign m1_ack    = ack_q &  owner_q;
  assign m0_rdata  = (m0_ack && !we_cap_q) ? mem_rdata : '0;
  assign m1_rdata  = (m1_ack && !we_cap_q) ? mem_rdata : '0;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign owner     = owner_q;

endmodule
